// File: rtl/riscv_pkg.sv
// Shared definitions for the PC sequencer: branch opcodes, FSM state
// encoding and the default datapath width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] BR_SEQ  = 3'd0;
  localparam logic [2:0] BR_ZER  = 3'd1;
  localparam logic [2:0] BR_NZR  = 3'd2;
  localparam logic [2:0] BR_DAT  = 3'd3;
  localparam logic [2:0] BR_NDT  = 3'd4;
  localparam logic [2:0] BR_JMP  = 3'd5;
  localparam logic [2:0] BR_JALR = 3'd6;
  localparam logic [2:0] BR_RSV  = 3'd7;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  // True for the flag-conditional branches (ZER, NZR, DAT, NDT).
  function automatic logic is_cond_branch(input logic [2:0] op);
    return (op >= BR_ZER) && (op <= BR_NDT);
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// Branch condition evaluation from the ALU flags. Purely combinational.
// Reserved opcode 7 behaves like SEQ (never taken).
module branch_cond
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      opcode,
  input  logic            br_valid,
  input  logic            z,
  input  logic [XLEN-1:0] d,
  output logic            cond
);

  // Decode the opcode into a take/no-take decision; no valid command means no branch.
  always_comb begin
    cond = 1'b0;
    if (br_valid) begin
      case (opcode)
        BR_ZER:           cond = z;
        BR_NZR:           cond = ~z;
        BR_DAT:           cond = |d;
        BR_NDT:           cond = ~(|d);
        BR_JMP, BR_JALR:  cond = 1'b1;
        BR_SEQ, BR_RSV:   cond = 1'b0;
        default:          cond = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer with branch evaluation, JALR target,
// link address and misaligned-target trap.
// Optional feature: define BRANCH_STATS_EN to add saturating taken/not-taken
// counters for the conditional branches (BR_TAKEN_CNT, BR_NTAKEN_CNT).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | normal sequencing; commands consumed on advance cycles
// ST_TRAP | one cycle after loading the trap vector; all inputs ignored
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              ILEN_BYTES   = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            BR_VALID,
  input  logic [2:0]      OPCODE,
  input  logic            Z,
  input  logic [XLEN-1:0] D,
  input  logic [XLEN-1:0] IMM,
  input  logic [XLEN-1:0] RS1,
  input  logic            HOLD,
  input  logic            FETCH_RDY,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] LINK,
  output logic            TAKEN,
  output logic            TRAP,
  output logic [XLEN-1:0] EPC
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     BR_TAKEN_CNT,
  output logic [31:0]     BR_NTAKEN_CNT
`endif
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            taken_q, taken_d;
  logic            trap_q, trap_d;

  logic            advance;
  logic            cond;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            misaligned;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .opcode   (OPCODE),
    .br_valid (BR_VALID),
    .z        (Z),
    .d        (D),
    .cond     (cond)
  );

  assign advance    = FETCH_RDY & ~HOLD;
  assign jalr_sum   = RS1 + IMM;
  assign target     = (OPCODE == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + IMM);
  assign misaligned = cond & ((target & ALIGN_MASK) != '0);

  // Next-state and next-PC selection; pulses default low so a stall never stretches them.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    taken_d = 1'b0;
    trap_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (advance) begin
          if (!cond) begin
            pc_d = pc_q + STEP;
          end else if (misaligned) begin
            pc_d    = TRAP_VECTOR;
            epc_d   = pc_q;
            trap_d  = 1'b1;
            state_d = ST_TRAP;
          end else begin
            pc_d    = target;
            taken_d = 1'b1;
          end
        end
      end
      ST_TRAP: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      taken_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      taken_q <= taken_d;
      trap_q  <= trap_d;
    end
  end

  assign PC    = pc_q;
  assign LINK  = pc_q + STEP;
  assign TAKEN = taken_q;
  assign TRAP  = trap_q;
  assign EPC   = epc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_taken_cnt_q, br_taken_cnt_d;
  logic [31:0] br_ntaken_cnt_q, br_ntaken_cnt_d;
  logic        count_en;

  // Only consumed, non-trapping conditional branches are counted.
  assign count_en = (state_q == ST_RUN) & advance & BR_VALID & is_cond_branch(OPCODE) & ~misaligned;

  // Saturating counter updates split by the branch outcome.
  always_comb begin
    br_taken_cnt_d  = br_taken_cnt_q;
    br_ntaken_cnt_d = br_ntaken_cnt_q;
    if (count_en) begin
      if (cond) begin
        if (br_taken_cnt_q != '1) br_taken_cnt_d = br_taken_cnt_q + 32'd1;
      end else begin
        if (br_ntaken_cnt_q != '1) br_ntaken_cnt_d = br_ntaken_cnt_q + 32'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      br_taken_cnt_q  <= '0;
      br_ntaken_cnt_q <= '0;
    end else begin
      br_taken_cnt_q  <= br_taken_cnt_d;
      br_ntaken_cnt_q <= br_ntaken_cnt_d;
    end
  end

  assign BR_TAKEN_CNT  = br_taken_cnt_q;
  assign BR_NTAKEN_CNT = br_ntaken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Expected PC/TAKEN/TRAP for each clock are
// queued when a command is driven and checked after the following edge.
module tb_pc_sequencer;
  import riscv_pkg::*;

  logic        CLK;
  logic        RST;
  logic        BR_VALID;
  logic [2:0]  OPCODE;
  logic        Z;
  logic [31:0] D;
  logic [31:0] IMM;
  logic [31:0] RS1;
  logic        HOLD;
  logic        FETCH_RDY;
  logic [31:0] PC;
  logic [31:0] LINK;
  logic        TAKEN;
  logic        TRAP;
  logic [31:0] EPC;
`ifdef BRANCH_STATS_EN
  logic [31:0] BR_TAKEN_CNT;
  logic [31:0] BR_NTAKEN_CNT;
`endif

  pc_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .BR_VALID  (BR_VALID),
    .OPCODE    (OPCODE),
    .Z         (Z),
    .D         (D),
    .IMM       (IMM),
    .RS1       (RS1),
    .HOLD      (HOLD),
    .FETCH_RDY (FETCH_RDY),
    .PC        (PC),
    .LINK      (LINK),
    .TAKEN     (TAKEN),
    .TRAP      (TRAP),
    .EPC       (EPC)
`ifdef BRANCH_STATS_EN
    ,
    .BR_TAKEN_CNT  (BR_TAKEN_CNT),
    .BR_NTAKEN_CNT (BR_NTAKEN_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        trap;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cmd(input logic v, input logic [2:0] op, input logic [31:0] imm);
    BR_VALID = v;
    OPCODE   = op;
    IMM      = imm;
  endtask

  // Queue the expectation, clock once, then pop and compare away from the edge.
  task automatic step(input string tag, input logic [31:0] pc, input logic tk, input logic tp);
    exp_t  e;
    string t;
    sb.push_back('{pc: pc, taken: tk, trap: tp});
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    t = tag_q.pop_front();
    chk({t, ".pc"},    PC,           e.pc);
    chk({t, ".taken"}, {31'b0, TAKEN}, {31'b0, e.taken});
    chk({t, ".trap"},  {31'b0, TRAP},  {31'b0, e.trap});
  endtask

  initial begin
    RST = 1'b0; BR_VALID = 1'b0; OPCODE = BR_SEQ; Z = 1'b0; D = '0;
    IMM = '0; RS1 = '0; HOLD = 1'b0; FETCH_RDY = 1'b0;
    #12;
    chk("rst.pc",    PC, 32'h0);
    chk("rst.taken", {31'b0, TAKEN}, 32'h0);
    chk("rst.trap",  {31'b0, TRAP},  32'h0);
    chk("rst.epc",   EPC, 32'h0);
    chk("rst.link",  LINK, 32'h4);
`ifdef BRANCH_STATS_EN
    chk("rst.tcnt",  BR_TAKEN_CNT, 32'h0);
    chk("rst.ncnt",  BR_NTAKEN_CNT, 32'h0);
`endif
    RST = 1'b1; FETCH_RDY = 1'b1;

    step("seq1", 32'h4, 1'b0, 1'b0);
    step("seq2", 32'h8, 1'b0, 1'b0);
    step("seq3", 32'hC, 1'b0, 1'b0);

    cmd(1'b1, BR_JMP, 32'h34);         step("jmp40",   32'h40, 1'b1, 1'b0);
    cmd(1'b1, BR_ZER, 32'hFFFF_FFF0); Z = 1'b1;
    step("zer_tk",  32'h30, 1'b1, 1'b0);
    cmd(1'b1, BR_JMP, 32'h10);         step("jmp40b",  32'h40, 1'b1, 1'b0);
    cmd(1'b1, BR_ZER, 32'hFFFF_FFF0); Z = 1'b0;
    step("zer_nt",  32'h44, 1'b0, 1'b0);
    cmd(1'b1, BR_DAT, 32'h8); D = 32'h0;
    step("dat_nt",  32'h48, 1'b0, 1'b0);
    cmd(1'b1, BR_NDT, 32'h8);          step("ndt_tk",  32'h50, 1'b1, 1'b0);
    cmd(1'b1, BR_DAT, 32'hFFFF_FFF0); D = 32'h100;
    step("dat_tk",  32'h40, 1'b1, 1'b0);
    cmd(1'b1, BR_RSV, 32'h8);          step("op7",     32'h44, 1'b0, 1'b0);
    cmd(1'b0, BR_JMP, 32'h8);          step("novalid", 32'h48, 1'b0, 1'b0);

    cmd(1'b1, BR_JMP, 32'hB8);         step("jmp100",  32'h100, 1'b1, 1'b0);
    chk("link100", LINK, 32'h104);
    cmd(1'b1, BR_JALR, 32'h3); RS1 = 32'h2001;
    step("jalr",    32'h2004, 1'b1, 1'b0);
    cmd(1'b1, BR_JALR, 32'h1); RS1 = 32'h2000;
    step("jalr_b0", 32'h2000, 1'b1, 1'b0);

    cmd(1'b1, BR_JMP, 32'hFFFF_E080);  step("jmp80",   32'h80, 1'b1, 1'b0);
    cmd(1'b1, BR_JMP, 32'h6);          step("mis_jmp", 32'h100, 1'b0, 1'b1);
    chk("epc80", EPC, 32'h80);
    FETCH_RDY = 1'b0;                  step("trap_st", 32'h100, 1'b0, 1'b0);
    FETCH_RDY = 1'b1; cmd(1'b0, BR_SEQ, 32'h0);
    step("post_trap", 32'h104, 1'b0, 1'b0);
    chk("epc_hold", EPC, 32'h80);
    cmd(1'b1, BR_ZER, 32'h6); Z = 1'b0;
    step("mis_nt",  32'h108, 1'b0, 1'b0);
    cmd(1'b1, BR_JALR, 32'h0); RS1 = 32'h2;
    step("mis_jalr", 32'h100, 1'b0, 1'b1);
    chk("epc108", EPC, 32'h108);
    cmd(1'b0, BR_SEQ, 32'h0);          step("trap_st2", 32'h100, 1'b0, 1'b0);

    cmd(1'b1, BR_JMP, 32'hFFFF_FF20);  step("jmp20",   32'h20, 1'b1, 1'b0);
    cmd(1'b1, BR_NZR, 32'h40); Z = 1'b0; HOLD = 1'b1;
    step("hold1",   32'h20, 1'b0, 1'b0);
    step("hold2",   32'h20, 1'b0, 1'b0);
    HOLD = 1'b0;                       step("nzr_tk",  32'h60, 1'b1, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("tcnt", BR_TAKEN_CNT, 32'd4);
    chk("ncnt", BR_NTAKEN_CNT, 32'd3);
`endif
    FETCH_RDY = 1'b0; cmd(1'b0, BR_SEQ, 32'h0);
    step("frdy0",   32'h60, 1'b0, 1'b0);
    FETCH_RDY = 1'b1; cmd(1'b1, BR_JMP, 32'hFFFF_FF9C);
    step("jmp_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("link_wrap", LINK, 32'h0);
    cmd(1'b0, BR_SEQ, 32'h0);          step("wrap",    32'h0, 1'b0, 1'b0);

    cmd(1'b1, BR_JMP, 32'h40);         step("jmp40c",  32'h40, 1'b1, 1'b0);
    cmd(1'b1, BR_JMP, 32'h2);          step("mis2",    32'h100, 1'b0, 1'b1);
    chk("epc40", EPC, 32'h40);
    #2 RST = 1'b0;
    #1;
    chk("arst.pc",   PC, 32'h0);
    chk("arst.trap", {31'b0, TRAP}, 32'h0);
    chk("arst.epc",  EPC, 32'h0);
    cmd(1'b0, BR_SEQ, 32'h0);
    #3 RST = 1'b1;
    step("rerun",   32'h4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
